// File: rtl/if_fetch_stage_if.sv
// Instruction-memory fetch bus between the IF stage and imem.
// req/addr hold until ack; rdata is valid in the ack cycle.
interface if_fetch_stage_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ack;
  logic [INST_W-1:0] rdata;

  modport master (
    output req, addr,
    input  ack, rdata
  );

  modport slave (
    input  req, addr,
    output ack, rdata
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC owner, imem requester, IF/ID register.
// One-entry holding buffer catches a fetch landing during a decode stall.
module if_fetch_stage #(
  parameter int              ADDR_W   = 32,
  parameter int              INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_addr_i,
  input  logic              ld_hold_i,
  input  logic              jmp_hold_i,
  if_fetch_stage_if.master  imem,
  output logic              if_valid_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [INST_W-1:0] if_inst_o
);

  typedef enum logic [1:0] {
    S_RST,
    S_IDLE,
    S_FETCH,
    S_DROP
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } slot_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] drop_q, drop_d;
  logic              hb_vld_q, hb_vld_d;
  slot_t             hb_q, hb_d;
  logic              v_q, v_d;
  slot_t             ifid_q, ifid_d;

  logic              stall;
  logic              go;
  logic              fetching;
  logic              take;
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] pc_inc;

  assign stall    = ld_hold_i | jmp_hold_i;
  assign tgt      = {redirect_addr_i[ADDR_W-1:2], 2'b00};
  assign pc_inc   = pc_q + ADDR_W'(4);
  // IDLE launches the fetch combinationally in the same cycle
  assign go       = (state_q == S_IDLE) & ~stall
                  & ~hb_vld_q & ~redirect_i;
  assign fetching = (state_q == S_FETCH) | go;
  assign take     = fetching & imem.ack;

  assign imem.req  = fetching | (state_q == S_DROP);
  assign imem.addr = (state_q == S_DROP) ? drop_q : pc_q;

  assign if_valid_o = v_q;
  assign if_pc_o    = ifid_q.pc;
  assign if_inst_o  = ifid_q.inst;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    drop_d   = drop_q;
    hb_vld_d = hb_vld_q;
    hb_d     = hb_q;
    v_d      = v_q;
    ifid_d   = ifid_q;

    unique case (state_q)
      S_RST: begin
        state_d = S_IDLE;
        if (redirect_i) pc_d = tgt;
      end
      S_IDLE, S_FETCH: begin
        if (redirect_i) begin
          pc_d = tgt;
          if (state_q == S_FETCH && !imem.ack) begin
            state_d = S_DROP;
            drop_d  = pc_q;
          end
        end else if (fetching) begin
          state_d = S_FETCH;
          if (imem.ack) begin
            pc_d = pc_inc;
            if (stall) begin
              hb_vld_d = 1'b1;
              hb_d     = '{pc: pc_q, inst: imem.rdata};
              state_d  = S_IDLE;
            end
          end
        end
      end
      S_DROP: begin
        if (redirect_i) pc_d = tgt;
        if (imem.ack) state_d = S_IDLE;
      end
      default: state_d = S_RST;
    endcase

    // IF/ID priority: flush, hold, drain buffer, fresh fetch, bubble
    if (redirect_i) begin
      v_d      = 1'b0;
      hb_vld_d = 1'b0;
    end else if (stall) begin
      v_d = v_q;
    end else if (hb_vld_q) begin
      v_d      = 1'b1;
      ifid_d   = hb_q;
      hb_vld_d = 1'b0;
    end else if (take) begin
      v_d    = 1'b1;
      ifid_d = '{pc: pc_q, inst: imem.rdata};
    end else begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_RST;
      pc_q     <= RESET_PC;
      drop_q   <= '0;
      hb_vld_q <= 1'b0;
      hb_q     <= '0;
      v_q      <= 1'b0;
      ifid_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      drop_q   <= drop_d;
      hb_vld_q <= hb_vld_d;
      hb_q     <= hb_d;
      v_q      <= v_d;
      ifid_q   <= ifid_d;
    end
  end

endmodule
